sample_rate_gen: RTL
====================

Name: sample_rate_gen

Overview:
- Downstream consumer of the frequency controller's half-period count (`half_num_clk_cycles`).
- Generates the divided playback clock and a one-cycle sample tick at the requested rate.
- Converts each tick into a request/acknowledge handshake to the flash sample reader.
- Reloads the period only on half-period boundaries, so speed changes never produce runt pulses.

Parameters:
- HALF_W, 16, width of the half-period count; matches the frequency controller output.
- MIN_HALF, 2, smallest half-period in clk cycles; smaller inputs are clamped up to this.

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous active-low reset
- half_cycles  in  HALF_W  half-period length in clk cycles, from the frequency controller
- enable  in  1  run/pause; low freezes all counting
- restart  in  1  synchronous restart of the divider phase
- sample_ack  in  1  reader has accepted the pending sample request
- clr_overrun  in  1  clears the sticky overrun flag
- div_clk  out  1  divided clock, 50% duty, period 2*eff_half
- tick  out  1  one-cycle strobe coincident with each div_clk rising edge
- sample_req  out  1  level request to the reader; held until acknowledged
- overrun  out  1  sticky; set when a tick arrives while a request is still pending

Behaviour:
- Reset (async, reset_n=0): cnt=0, div_clk=0, tick=0, sample_req=0, overrun=0. All outputs are registered.
- eff_half = (half_cycles < MIN_HALF) ? MIN_HALF : half_cycles. The value is sampled only in the reload cycle.
- Divider, enable=1, restart=0:
  - cnt != 0: cnt decrements.
  - cnt == 0: div_clk toggles and cnt <= eff_half-1.
  - First toggle occurs in the first enabled cycle after reset. Each half-period then lasts exactly eff_half cycles.
- half_cycles changing mid half-period has no effect until the next reload. No glitches or truncated half-periods.
- enable=0: cnt and div_clk hold, tick=0, the handshake still operates (ack still clears req).
- restart=1 (priority over enable): cnt=0, div_clk=0, tick=0. The next enabled cycle toggles div_clk high with a tick. sample_req and overrun are unaffected.
- tick: 1 in the cycle div_clk registers 0->1; 0 otherwise. Falling toggles produce no tick.
- Handshake, evaluated per cycle:
  - tick & !sample_req: sample_req <= 1.
  - sample_req & sample_ack & !tick: sample_req <= 0.
  - sample_req & sample_ack & tick: sample_req stays 1 (new request). overrun is not set.
  - sample_req & !sample_ack & tick: sample_req stays 1 and overrun <= 1.
  - sample_ack while sample_req=0: ignored.
- overrun: cleared by clr_overrun. If set and clear occur in the same cycle, the set wins.
- Arithmetic: cnt is HALF_W bits, unsigned, and never underflows because the zero case reloads. half_cycles=0xFFFF is legal (period 131070 cycles).
- Reset asserted mid-period: immediate return to reset values. The first toggle after release follows the rule above.

Optional Feature:
- Macro: SAMPLE_RATE_OVR_CNT_EN.
- Defined: adds output ovr_count[7:0].
  - Saturating count of overrun events: +1 on each tick that hits a pending request, saturating at 0xFF.
  - Cleared by clr_overrun and by reset.
- Undefined: the port and counter are absent; only the sticky overrun flag exists.

Decomposition:
- Shared package ipod_pkg:
  - HALF_W, MIN_HALF default, SYS_CLK_FREQ_HALF constant.
  - typedef half_cnt_t = logic [HALF_W-1:0].
  - Shared with the frequency controller.
- One sub-module is natural: sample_req_hs, the req/ack/overrun logic (plus the optional counter), driven by tick.
- The divider stays in the top module.

Test Plan:
- half_cycles=4, enable=1 after reset: div_clk toggles every 4 cycles, tick every 8 cycles, first tick in the first enabled cycle.
- half_cycles 4->6 two cycles into a half-period: that half-period still lasts 4 cycles, the following ones last 6, no runt pulse.
- half_cycles=0 then 1: divider runs with eff_half=2 (period 4 cycles), no lockup.
- Ack never driven across two ticks (half=4):
  - sample_req stays 1 and overrun=1 at the second tick.
  - ovr_count=1 when the macro is enabled.
  - clr_overrun then returns overrun to 0.
- sample_ack in a tick cycle with req pending: req stays 1, overrun stays 0. Ack one cycle later drops req.
- reset_n pulsed low mid half-period with req pending: all outputs 0 immediately. After release, a tick occurs in the first enabled cycle.

Source files
------------

// File: rtl/ipod_pkg.sv
// Shared constants and types for the playback clocking path.
// Also used by the frequency controller that produces half_cycles.
package ipod_pkg;

   localparam int HALF_W = 16;
   localparam int MIN_HALF = 2;
   localparam int SYS_CLK_FREQ_HALF = 25_000_000;
   localparam int OVR_W = 8;

   typedef logic [HALF_W-1:0] half_cnt_t;

endpackage

// File: rtl/sample_req_hs.sv
// Request/acknowledge handshake to the flash reader, plus sticky overrun.
// SAMPLE_RATE_OVR_CNT_EN adds a saturating overrun event counter.
module sample_req_hs
   import ipod_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic sample_ack,
   input  logic clr_overrun,
   output logic sample_req,
   output logic overrun
`ifdef SAMPLE_RATE_OVR_CNT_EN
   ,
   output logic [OVR_W-1:0] ovr_count
`endif
);

   logic hit;

   // a new tick while the previous request is still unacknowledged
   assign hit = tick & sample_req & ~sample_ack;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sample_req <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (tick)
            sample_req <= 1'b1;
         else if (sample_ack)
            sample_req <= 1'b0;

         if (hit)
            overrun <= 1'b1;
         else if (clr_overrun)
            overrun <= 1'b0;
      end
   end

`ifdef SAMPLE_RATE_OVR_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovr_count <= '0;
      end else if (hit) begin
         if (ovr_count != '1)
            ovr_count <= ovr_count + 1'b1;
      end else if (clr_overrun) begin
         ovr_count <= '0;
      end
   end
`endif

endmodule

// File: rtl/sample_rate_gen.sv
// Divided playback clock, sample tick and reader handshake.
// Optional overrun counter port under SAMPLE_RATE_OVR_CNT_EN.
module sample_rate_gen #(
   parameter int HALF_W   = ipod_pkg::HALF_W,
   parameter int MIN_HALF = ipod_pkg::MIN_HALF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [HALF_W-1:0] half_cycles,
   input  logic              enable,
   input  logic              restart,
   input  logic              sample_ack,
   input  logic              clr_overrun,
   output logic              div_clk,
   output logic              tick,
   output logic              sample_req,
   output logic              overrun
`ifdef SAMPLE_RATE_OVR_CNT_EN
   ,
   output logic [7:0]        ovr_count
`endif
);

   logic [HALF_W-1:0] cnt;
   logic [HALF_W-1:0] eff_half;

   assign eff_half = (half_cycles < HALF_W'(MIN_HALF)) ?
                     HALF_W'(MIN_HALF) : half_cycles;

   // period is only reloaded at cnt==0, so no half-period is ever cut short
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         div_clk <= 1'b0;
         tick    <= 1'b0;
      end else begin
         priority case (1'b1)
            restart: begin
               cnt     <= '0;
               div_clk <= 1'b0;
               tick    <= 1'b0;
            end
            enable: begin
               if (cnt == '0) begin
                  div_clk <= ~div_clk;
                  tick    <= ~div_clk;
                  cnt     <= eff_half - HALF_W'(1);
               end else begin
                  cnt  <= cnt - HALF_W'(1);
                  tick <= 1'b0;
               end
            end
            default: tick <= 1'b0;
         endcase
      end
   end

   sample_req_hs u_hs (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick        (tick),
      .sample_ack  (sample_ack),
      .clr_overrun (clr_overrun),
      .sample_req  (sample_req),
      .overrun     (overrun)
`ifdef SAMPLE_RATE_OVR_CNT_EN
      ,
      .ovr_count   (ovr_count)
`endif
   );

endmodule
